// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_scheduler
// Purpose  : Shares a single-port framebuffer RAM between beam-locked scanout
//            reads and round-robin host read/write traffic.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_scheduler #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        s_x,
    input  logic [9:0]        s_y,
    input  logic              data_enable,
    input  logic              h_sync,
    input  logic              v_sync,
    output logic [PIX_W-1:0]  pix_out,
    output logic              de_out,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [PIX_W-1:0]  rd_resp_data
);

    localparam logic [ADDR_W:0] c_fb_size  = (ADDR_W+1)'(FB_W * FB_H);
    localparam logic [9:0]      c_sub_mask = 10'((1 << SCALE_LOG2) - 1);

    logic              w_disp_slot;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [PIX_W-1:0]  w_resp_now;

    logic              r_rr;        // 0: write wins a contested cycle, 1: read wins
    logic              r_rd_pend;
    logic              r_rd_host;   // tag of the read issued last cycle
    logic              r_rd_oor;
    logic [PIX_W-1:0]  r_pix_hold;
    logic [PIX_W-1:0]  r_resp_data;
    logic [1:0]        r_de;
    logic [1:0]        r_hs;
    logic [1:0]        r_vs;

    assign w_disp_slot = data_enable && ((s_x & c_sub_mask) == 10'd0);
    assign w_row       = ADDR_W'(s_y >> SCALE_LOG2);
    assign w_col       = ADDR_W'(s_x >> SCALE_LOG2);
    assign w_disp_addr = w_row * ADDR_W'(FB_W) + w_col;

    assign w_wr_in_range = {1'b0, wr_addr} < c_fb_size;
    assign w_rd_in_range = {1'b0, rd_addr} < c_fb_size;

    // Readies look only at the opposite valid, so at most one handshake fires.
    assign wr_ready  = !w_disp_slot && (!rd_valid || !r_rr);
    assign rd_ready  = !w_disp_slot && (!wr_valid ||  r_rr);
    assign w_wr_fire = wr_valid && wr_ready;
    assign w_rd_fire = rd_valid && rd_ready;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_disp_slot) begin
            mem_en   = 1'b1;
            mem_addr = w_disp_addr;
        end else if (w_wr_fire) begin
            mem_en    = w_wr_in_range;
            mem_we    = w_wr_in_range;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (w_rd_fire) begin
            mem_en   = w_rd_in_range;
            mem_addr = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr        <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_host   <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_pix_hold  <= '0;
            r_resp_data <= '0;
            r_de        <= 2'b00;
            r_hs        <= 2'b11;
            r_vs        <= 2'b11;
        end else begin
            r_de <= {r_de[0], data_enable};
            r_hs <= {r_hs[0], h_sync};
            r_vs <= {r_vs[0], v_sync};
            if (!w_disp_slot && wr_valid && rd_valid) begin
                r_rr <= ~r_rr;
            end
            r_rd_pend <= w_disp_slot || w_rd_fire;
            r_rd_oor  <= w_rd_fire && !w_rd_in_range;
            if (w_disp_slot || w_rd_fire) begin
                r_rd_host <= !w_disp_slot;
            end
            if (r_rd_pend) begin
                if (r_rd_host) begin
                    r_resp_data <= w_resp_now;
                end else begin
                    r_pix_hold <= mem_rdata;
                end
            end
        end
    end

    // A response in its return cycle is passed straight through, then held.
    assign w_resp_now    = r_rd_oor ? '0 : mem_rdata;
    assign rd_resp_valid = r_rd_pend && r_rd_host && !reset;
    assign rd_resp_data  = rd_resp_valid ? w_resp_now : r_resp_data;

    assign de_out     = r_de[1];
    assign h_sync_out = r_hs[1];
    assign v_sync_out = r_vs[1];
    assign pix_out    = r_de[1] ? r_pix_hold : '0;

endmodule
`default_nettype wire
